mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum consecutive data grants while a fetch waits.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles for mem_ready before an aborted transaction.
REQ-003 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 if_req  in  1  fetch request; if_addr  in  32  fetch address.
REQ-006 if_ack  out  1  one-cycle fetch completion pulse; if_rdata  out  32  fetched instruction, valid while if_ack=1.
REQ-007 d_req  in  1  data request; d_we  in  1  1=store, 0=load; d_addr  in  32  data address; d_wdata  in  32  store data; d_size  in  2  access size, passed through unchanged.
REQ-008 d_ack  out  1  one-cycle data completion pulse; d_rdata  out  32  load data, valid while d_ack=1.
REQ-009 mem_addr  out  32; mem_wdata  out  32; mem_re  out  1; mem_we  out  1; mem_size  out  2: the shared memory port.
REQ-010 mem_rdata  in  32  memory read data; mem_ready  in  1  memory completes the current access this cycle.
REQ-011 err  out  1  pulses with if_ack or d_ack when that transaction timed out.
REQ-012 stall  out  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack).

Function
REQ-013 The FSM SHALL have three states: IDLE, GNT_I and GNT_D.
REQ-014 In IDLE with no unmasked request, the FSM SHALL stay in IDLE with mem_re=mem_we=0.
REQ-015 In IDLE with a single unmasked request, the FSM SHALL go to that requester's GNT state on the next edge.
REQ-016 In IDLE with both requests unmasked, the FSM SHALL grant data unless starve_cnt==STARVE_LIMIT, in which case it SHALL grant fetch.
REQ-017 A requester whose ack is high in the current cycle SHALL be masked from arbitration in that cycle.
REQ-018 On the grant edge, the arbiter SHALL latch address, wdata, we and size into registers that drive mem_*.
  - Requester input changes after the grant SHALL NOT affect the transaction.
  - For a fetch grant, mem_size=2'b10 and mem_we=0.
REQ-019 In GNT_x, the arbiter SHALL hold mem_re=~we or mem_we=we, depending on the latched we.
REQ-020 On an edge in GNT_x with mem_ready=1, the arbiter SHALL:
  - register mem_rdata into x_rdata (0 for stores);
  - pulse x_ack for exactly one cycle;
  - drop mem_re/mem_we;
  - return to IDLE.
REQ-021 Minimum latency SHALL be 2 cycles: req sampled at edge 1 (grant), mem_ready=1 during the following cycle, ack high after edge 2. Back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-022 The 8-bit wait_cnt SHALL clear on grant and increment each GNT cycle without mem_ready.
REQ-023 When wait_cnt reaches TIMEOUT, the arbiter SHALL pulse x_ack and err together, with x_rdata=0, and return to IDLE.
REQ-024 starve_cnt (2 bits) SHALL be updated on each grant:
  - increment, saturating at STARVE_LIMIT, on a data grant taken while if_req=1;
  - clear on a fetch grant;
  - clear on a data grant taken while if_req=0.
REQ-025 mem_ready while in IDLE SHALL be ignored.
REQ-026 A requester dropping req mid-grant SHALL NOT abort the transaction; its ack is still issued.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force:
  - state=IDLE;
  - mem_re=mem_we=0; if_ack=d_ack=err=0;
  - mem_addr, mem_wdata, if_rdata and d_rdata to 0; mem_size=0;
  - wait_cnt=starve_cnt=0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no ack issued, including after rst_n deassertion.
REQ-029 The first grant after reset SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x100, mem_ready=1 in the GNT cycle, mem_rdata=0x00500093 -> mem_re=1 and mem_addr=0x100 for one cycle, then if_ack=1 with if_rdata=0x00500093, err=0.
REQ-031 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=2, mem_ready delayed 3 cycles -> mem_we held 4 cycles with stable address and data, then d_ack=1, d_rdata=0.
REQ-032 Simultaneous requests held continuously, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I.
REQ-033 Timeout: load with mem_ready tied 0, TIMEOUT=255 -> d_ack=err=1 exactly 255 cycles after grant, d_rdata=0, then IDLE.
REQ-034 Reset mid-transaction: rst_n=0 during GNT_D -> mem_we and mem_re fall immediately with no ack; after release, a new if_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared memory port signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;
  // Fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  // Data requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_ack;
  logic [31:0] d_rdata;
  // Shared memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // Status
  logic        err;
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, mem_size,
           err, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, mem_size,
           err, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch and a data
// requester. Data normally wins; a waiting fetch is forced through after
// STARVE_LIMIT consecutive data grants. Each transaction is latched on its
// grant edge, completes on mem_ready, or is aborted with err after TIMEOUT
// wait cycles. The ack cycle doubles as the idle gap between grants, so no
// new grant is issued while an ack is out.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
  // The abort edge is the one on which wait_cnt steps to TIMEOUT.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  starve_q, starve_d;

  logic        req_i;
  logic        req_d;
  logic        ack_out;
  logic [31:0] rdata_next;

  // A requester being acked this cycle is still showing the request that was
  // just served, so it is masked out of arbitration.
  assign req_i   = bus.if_req & ~if_ack_q;
  assign req_d   = bus.d_req  & ~d_ack_q;
  assign ack_out = if_ack_q | d_ack_q;

  // Next-state, grant latching, completion and timeout handling.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    rdata_next  = '0;

    unique case (state_q)
      IDLE: begin
        if (!ack_out) begin
          if (req_d && !(req_i && starve_q == STARVE_MAX)) begin
            state_d     = GNT_D;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_size_d  = bus.d_size;
            mem_re_d    = ~bus.d_we;
            mem_we_d    = bus.d_we;
            wait_d      = '0;
            if (bus.if_req) begin
              starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 2'd1;
            end else begin
              starve_d = '0;
            end
          end else if (req_i) begin
            state_d     = GNT_I;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_size_d  = 2'b10;
            mem_re_d    = 1'b1;
            mem_we_d    = 1'b0;
            wait_d      = '0;
            starve_d    = '0;
          end
        end
      end

      GNT_I, GNT_D: begin
        if (bus.mem_ready || wait_q == WAIT_LAST) begin
          state_d    = IDLE;
          mem_re_d   = 1'b0;
          mem_we_d   = 1'b0;
          // Stores and aborted transactions return zero data.
          rdata_next = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
          err_d      = ~bus.mem_ready;
          if (state_q == GNT_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = rdata_next;
          end else begin
            d_ack_d    = 1'b1;
            d_rdata_d  = rdata_next;
          end
        end
        if (!bus.mem_ready) begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of per-cycle vectors for
// single fetch/store/load traffic, then hand-written sequences for starvation
// ordering, timeout and reset in the middle of a transaction.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .STARVE_LIMIT(3),
    .TIMEOUT     (255)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_re;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_size;
    logic        e_if_ack;
    logic        e_d_ack;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.if_req    = v.if_req;
    bus.if_addr   = v.if_addr;
    bus.d_req     = v.d_req;
    bus.d_we      = v.d_we;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.d_size    = v.d_size;
    bus.mem_ready = v.mem_ready;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_re"},   32'(bus.mem_re),   32'd0);
    check({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
    check({tag, "_if_ack"},   32'(bus.if_ack),   32'd0);
    check({tag, "_d_ack"},    32'(bus.d_ack),    32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr,      32'd0);
    check({tag, "_mem_wdata"},bus.mem_wdata,     32'd0);
    check({tag, "_mem_size"}, 32'(bus.mem_size), 32'd0);
    check({tag, "_if_rdata"}, bus.if_rdata,      32'd0);
    check({tag, "_d_rdata"},  bus.d_rdata,       32'd0);
  endtask

  initial begin
    string order;
    int    grants;
    int    k;
    bit    re_held;

    // Inputs during cycle -> expected outputs just after the following edge.
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h00500093,
                 1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h00500093, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hFFFF0000,
                 1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h12345678, 2'd1, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h12345678, 2'd1, 1'b1, 32'hCAFEF00D,
                 1'b0, 1'b0, 32'h2000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h2000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, 2'd0, 1'b1, 32'h11223344,
                 1'b0, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h11223344, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h55555555,
                 1'b0, 1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    drive(vecs[8]);
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single fetch, delayed store, load with dropped request, idle mem_ready
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("r%0d_mem_re", i),    32'(bus.mem_re),   32'(vecs[i].e_re));
      check($sformatf("r%0d_mem_we", i),    32'(bus.mem_we),   32'(vecs[i].e_we));
      check($sformatf("r%0d_mem_addr", i),  bus.mem_addr,      vecs[i].e_addr);
      check($sformatf("r%0d_mem_wdata", i), bus.mem_wdata,     vecs[i].e_wdata);
      check($sformatf("r%0d_mem_size", i),  32'(bus.mem_size), 32'(vecs[i].e_size));
      check($sformatf("r%0d_if_ack", i),    32'(bus.if_ack),   32'(vecs[i].e_if_ack));
      check($sformatf("r%0d_d_ack", i),     32'(bus.d_ack),    32'(vecs[i].e_d_ack));
      check($sformatf("r%0d_err", i),       32'(bus.err),      32'(vecs[i].e_err));
      check($sformatf("r%0d_stall", i),     32'(bus.stall),    32'(vecs[i].e_stall));
      if (vecs[i].e_if_ack) check($sformatf("r%0d_if_rdata", i), bus.if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_ack)  check($sformatf("r%0d_d_rdata", i),  bus.d_rdata,  vecs[i].e_rdata);
    end

    // Starvation: both requests held, memory always ready
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h500;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h600;
    bus.d_size    = 2'd0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0;
    order  = "";
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      step();
      if (bus.mem_re) begin
        order = {order, (bus.mem_addr == 32'h600) ? "D" : "I"};
        grants++;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check("starve_grant_count", 32'(grants), 32'd8);
    checks++;
    if (order != "DDDIDDDI") begin
      failures++;
      $display("FAIL starve_order: got %s expected DDDIDDDI", order);
    end
    step();
    step();

    // Timeout: load with mem_ready held low
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h80;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFFFFFF;
    step();
    check("to_grant_mem_re", 32'(bus.mem_re), 32'd1);
    bus.d_req = 1'b0;
    k       = 0;
    re_held = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step();
      k++;
      if (bus.d_ack) break;
      if (!bus.mem_re) re_held = 1'b0;
    end
    check("to_cycles",   32'(k),           32'd255);
    check("to_re_held",  32'(re_held),     32'd1);
    check("to_err",      32'(bus.err),     32'd1);
    check("to_d_rdata",  bus.d_rdata,      32'd0);
    check("to_mem_re",   32'(bus.mem_re),  32'd0);
    step();
    check("to_after_ack", 32'(bus.d_ack),  32'd0);
    check("to_after_err", 32'(bus.err),    32'd0);

    // Reset in the middle of a store
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h44;
    bus.d_wdata   = 32'h77;
    bus.mem_ready = 1'b0;
    step();
    check("rst_pre_mem_we", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    bus.d_req     = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h104;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00000013;
    step();
    check("rst_held_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_held_d_ack",  32'(bus.d_ack),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    step();
    check("rst_fetch_mem_re",   32'(bus.mem_re),   32'd1);
    check("rst_fetch_addr",     bus.mem_addr,      32'h104);
    check("rst_fetch_size",     32'(bus.mem_size), 32'd2);
    check("rst_fetch_no_d_ack", 32'(bus.d_ack),    32'd0);
    bus.mem_ready = 1'b1;
    step();
    check("rst_fetch_if_ack", 32'(bus.if_ack), 32'd1);
    check("rst_fetch_rdata",  bus.if_rdata,    32'h00000013);
    check("rst_fetch_err",    32'(bus.err),    32'd0);
    check("rst_fetch_d_ack",  32'(bus.d_ack),  32'd0);
    bus.if_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
